alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_core.sv | 28 ++
 rtl/alu_exec.sv | 106 ++++++++++
 tb/tb_alu_exec.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings (also used by the ALU control
// stage), execute-stage FSM states and a shift-code helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_OR  = 4'h1,
    OP_ADD = 4'h2,
    OP_SLL = 4'h3,
    OP_SUB = 4'h6,
    OP_XOR = 4'h7,
    OP_SRL = 4'h8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == OP_SLL) || (code == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Handshake bundle between decode stage, ALU execute stage and result consumer.
interface alu_exec_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_decode;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;

  modport master (
    output in_valid, alu_decode, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_decode, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath. Barrel shifter is present only when
// ALU_FAST_SHIFT_EN is defined; otherwise shift codes yield 0 here.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]        code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (code)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_XOR:  y = a ^ b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  y = a << b[SHAMT_W-1:0];
      OP_SRL:  y = a >> b[SHAMT_W-1:0];
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready handshake, registered result/zero, iterative
// one-bit-per-cycle shifter (single-cycle when ALU_FAST_SHIFT_EN is defined).
module alu_exec
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic                left_q, left_d;
  logic [DATA_W-1:0]   core_y;
  logic [DATA_W-1:0]   shifted;

  alu_core u_core (
    .code (bus.alu_decode),
    .a    (bus.op_a),
    .b    (bus.op_b),
    .y    (core_y)
  );

  assign shifted = left_q ? {work_q[DATA_W-2:0], 1'b0} : {1'b0, work_q[DATA_W-1:1]};

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    work_d   = work_q;
    count_d  = count_q;
    left_d   = left_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
            result_d = core_y;
            zero_d   = (core_y == '0);
            state_d  = DONE;
`else
            if (is_shift(bus.alu_decode) && (bus.op_b[SHAMT_W-1:0] != '0)) begin
              work_d  = bus.op_a;
              count_d = bus.op_b[SHAMT_W-1:0];
              left_d  = (bus.alu_decode == OP_SLL);
              state_d = SHIFT;
            end else if (is_shift(bus.alu_decode)) begin
              result_d = bus.op_a;
              zero_d   = (bus.op_a == '0);
              state_d  = DONE;
            end else begin
              result_d = core_y;
              zero_d   = (core_y == '0);
              state_d  = DONE;
            end
`endif
          end
        end
        SHIFT: begin
          // result/zero are only updated on the final step, so intermediate
          // shift values never reach the outputs.
          work_d  = shifted;
          count_d = count_q - 1'b1;
          if (count_q == SHAMT_W'(1)) begin
            result_d = shifted;
            zero_d   = (shifted == '0);
            state_d  = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      work_q   <= '0;
      count_q  <= '0;
      left_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      work_q   <= work_d;
      count_q  <= count_d;
      left_q   <= left_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: vector table plus scoreboard, with hand-written
// flush and reset sequences. Honours ALU_FAST_SHIFT_EN for expected latency.
module tb_alu_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_if bus();

  alu_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    int unsigned hold;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   ov_seen;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_latency(input logic [3:0] code, input logic [31:0] b);
    int unsigned lat;
    lat = 1;
`ifndef ALU_FAST_SHIFT_EN
    if ((code == 4'h3 || code == 4'h8) && b[4:0] != 5'd0) lat = int'(b[4:0]) + 1;
`endif
    return lat;
  endfunction

  // Scoreboard consumer: compares on every completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result 0x%08h with empty scoreboard", bus.result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, bus.result, mon_e.res);
        check({mon_e.name, "_zero"}, 32'(bus.zero), 32'(mon_e.zero));
      end
    end
  end

  always @(negedge clk) if (bus.out_valid) ov_seen = 1'b1;

  task automatic run_op(input string name, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic zero,
                        input int unsigned hold);
    int unsigned lat;
    bit seen;
    @(posedge clk); #1;
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.alu_decode = code;
    bus.op_a       = a;
    bus.op_b       = b;
    @(posedge clk);
    sb.push_back('{name, res, zero});
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat  = n;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid not seen within 100 cycles, expected latency %0d",
               name, exp_latency(code, b));
      sb.delete(sb.size() - 1);
      return;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_latency(code, b)));
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_stall_result"}, bus.result, res);
      check({name, "_stall_zero"}, 32'(bus.zero), 32'(zero));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",   4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 0};
    vecs[1]  = '{"sub_zero",  4'h6, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 3};
    vecs[2]  = '{"and",       4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 0};
    vecs[3]  = '{"or",        4'h1, 32'h0000_00FF, 32'h1200_0000, 32'h1200_00FF, 1'b0, 1};
    vecs[4]  = '{"xor_self",  4'h7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 0};
    vecs[5]  = '{"sub_wrap",  4'h6, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0};
    vecs[6]  = '{"add_wrap",  4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0};
    vecs[7]  = '{"sll_31",    4'h3, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 0};
    vecs[8]  = '{"srl_0",     4'h8, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 0};
    vecs[9]  = '{"srl_4",     4'h8, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 2};
    vecs[10] = '{"sll_hibits",4'h3, 32'h0000_0003, 32'hFFFF_FF25, 32'h0000_0060, 1'b0, 0};
    vecs[11] = '{"srl_out",   4'h8, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 0};
    vecs[12] = '{"code4",     4'h4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 0};
    vecs[13] = '{"code_f",    4'hF, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 1'b1, 0};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.alu_decode = 4'h0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'h0);
    check("reset_zero", 32'(bus.zero), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].hold);

    // flush wins over in_valid in IDLE: nothing accepted
    @(posedge clk); #1;
    ov_seen        = 1'b0;
    bus.in_valid   = 1'b1;
    bus.alu_decode = 4'h2;
    bus.op_a       = 32'd1;
    bus.op_b       = 32'd1;
    bus.flush      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_idle_no_valid", 32'(ov_seen), 32'd0);

    // SRL by 4 aborted by flush two cycles after acceptance
    @(posedge clk); #1;
    ov_seen        = 1'b0;
    bus.in_valid   = 1'b1;
    bus.alu_decode = 4'h8;
    bus.op_a       = 32'hF000_0000;
    bus.op_b       = 32'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_shift_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_shift_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (8) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    check("flush_shift_never_valid", 32'(ov_seen), 32'd0);
`endif
    check("flush_shift_still_idle", 32'(bus.in_ready), 32'd1);

    // reset in the middle of a long shift
    run_op("pre_rst_add", 4'h2, 32'd1, 32'd2, 32'd3, 1'b0, 0);
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.alu_decode = 4'h3;
    bus.op_a       = 32'h0000_0001;
    bus.op_b       = 32'd31;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'h0);
    check("rst_mid_zero", 32'(bus.zero), 32'd1);
    @(posedge clk); #1;
    rst     = 1'b0;
    ov_seen = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_no_valid_after", 32'(ov_seen), 32'd0);
    run_op("post_rst_code_f", 4'hF, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0, 1'b1, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
